// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared types and helpers for the line-window controller
//
// Purpose: read-FSM state enum, default geometry, pointer-width and
//          window bit-index helpers.
// Ports:   none (package).
package img_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int LINE_LEN_DEF = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } img_state_e;

  // Pointer width for a counter over n entries; never narrower than 1 bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of window element (r,c); r=0 is the oldest line, c=0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int k, input int w);
    return (r * k + c) * w;
  endfunction

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - one image line with a write port and KSIZE adjacent read taps
//
// Purpose: stores LINE_LEN pixels; taps[c] shows column rcol+c combinationally.
// Ports:   clk    - write clock
//          we     - write enable
//          waddr  - write column
//          wdata  - write pixel
//          rcol   - leftmost read column
//          taps   - KSIZE pixels, tap c at bits [c*DATA_W +: DATA_W]
module line_buf
  import img_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int KSIZE    = 3
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_w(LINE_LEN)-1:0]    waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [ptr_w(LINE_LEN)-1:0]    rcol,
  output logic [KSIZE*DATA_W-1:0]       taps
);

  localparam int CW = ptr_w(LINE_LEN);

  logic [DATA_W-1:0] mem [LINE_LEN];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar c = 0; c < KSIZE; c++) begin : g_tap
    logic [CW:0] idx;
    assign idx = {1'b0, rcol} + (CW+1)'(c);
    // The controller never reads past the line end; the guard keeps the
    // index in range for any rcol value.
    assign taps[c*DATA_W +: DATA_W] = (idx < (CW+1)'(LINE_LEN)) ? mem[idx[CW-1:0]] : '0;
  end

endmodule

// File: rtl/line_window_ctrl.sv
// rtl/line_window_ctrl.sv - ring of line buffers emitting KSIZE x KSIZE windows
//
// Purpose: accepts a raster pixel stream, holds it in NUM_LINES line buffers and
//          streams every KSIZE x KSIZE window of each line set downstream.
// Ports:   axi_clk       - clock, rising edge
//          axi_reset     - asynchronous active-low reset
//          i_data_valid  - input pixel valid
//          i_data        - input pixel, raster order
//          o_data_ready  - input accepted when high (occupancy < NUM_LINES)
//          o_win_valid   - window valid
//          o_win_data    - window, element (r,c) at win_idx(r,c)
//          i_win_ready   - downstream accepts window
//          o_intr        - one-cycle pulse when a line is released
//          o_occupancy   - complete, unreleased lines
module line_window_ctrl
  import img_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LINE_LEN  = LINE_LEN_DEF,
  parameter int NUM_LINES = 4,
  parameter int KSIZE     = 3
) (
  input  logic                             axi_clk,
  input  logic                             axi_reset,
  input  logic                             i_data_valid,
  input  logic [DATA_W-1:0]                i_data,
  output logic                             o_data_ready,
  output logic                             o_win_valid,
  output logic [KSIZE*KSIZE*DATA_W-1:0]    o_win_data,
  input  logic                             i_win_ready,
  output logic                             o_intr,
  output logic [$clog2(NUM_LINES+1)-1:0]   o_occupancy
);

  localparam int CW = ptr_w(LINE_LEN);
  localparam int LW = ptr_w(NUM_LINES);
  localparam int OW = $clog2(NUM_LINES+1);
  localparam int WW = KSIZE*KSIZE*DATA_W;

  localparam logic [CW-1:0] COL_LAST    = CW'(LINE_LEN-1);
  localparam logic [CW-1:0] RD_COL_LAST = CW'(LINE_LEN-KSIZE);
  localparam logic [LW-1:0] LINE_LAST   = LW'(NUM_LINES-1);
  localparam logic [OW-1:0] OCC_FULL    = OW'(NUM_LINES);
  localparam logic [OW-1:0] OCC_K       = OW'(KSIZE);

  img_state_e        state_q, state_d;
  logic [CW-1:0]     wr_col_q, wr_col_d;
  logic [LW-1:0]     wr_line_q, wr_line_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic [LW-1:0]     rd_base_q, rd_base_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              win_valid_q, win_valid_d;
  logic [WW-1:0]     win_data_q, win_data_d;
  logic              intr_q, intr_d;

  logic              wr_en;
  logic              line_done;
  logic              rel_ev;
  logic [WW-1:0]     win_mux;
  logic [NUM_LINES-1:0][KSIZE*DATA_W-1:0] taps;

  assign o_data_ready = (occ_q < OCC_FULL);
  assign wr_en        = i_data_valid && o_data_ready;
  assign line_done    = wr_en && (wr_col_q == COL_LAST);
  // The last window of a line set is accepted: the oldest line is released.
  assign rel_ev       = (state_q == DRAIN) && i_win_ready;

  assign o_win_valid  = win_valid_q;
  assign o_win_data   = win_data_q;
  assign o_intr       = intr_q;
  assign o_occupancy  = occ_q;

  // Line storage; the write line always sits just past the occupied lines,
  // so it never aliases a line being read.
  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    line_buf #(
      .DATA_W  (DATA_W),
      .LINE_LEN(LINE_LEN),
      .KSIZE   (KSIZE)
    ) u_line (
      .clk  (axi_clk),
      .we   (wr_en && (wr_line_q == LW'(l))),
      .waddr(wr_col_q),
      .wdata(i_data),
      .rcol (rd_col_q),
      .taps (taps[l])
    );
  end

  // Window row r comes from ring line rd_base+r; one conditional subtract
  // suffices since r < NUM_LINES.
  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    logic [LW:0]   sum;
    logic [LW-1:0] ln;
    assign sum = {1'b0, rd_base_q} + (LW+1)'(r);
    assign ln  = (sum >= (LW+1)'(NUM_LINES)) ? LW'(sum - (LW+1)'(NUM_LINES)) : sum[LW-1:0];
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
      assign win_mux[win_idx(r, c, KSIZE, DATA_W) +: DATA_W] = taps[ln][c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    wr_col_d  = wr_col_q;
    wr_line_d = wr_line_q;
    if (wr_en) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d  = '0;
        wr_line_d = (wr_line_q == LINE_LAST) ? '0 : wr_line_q + LW'(1);
      end else begin
        wr_col_d  = wr_col_q + CW'(1);
      end
    end
  end

  // A simultaneous line-complete and release leaves occupancy unchanged.
  always_comb begin
    occ_d = occ_q;
    if (line_done && !rel_ev) begin
      occ_d = occ_q + OW'(1);
    end else if (rel_ev && !line_done) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    rd_base_d   = rd_base_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    intr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (occ_q >= OCC_K) begin
          state_d  = RUN;
          rd_col_d = '0;
        end
      end
      RUN: begin
        // Load only when the output register is empty or being drained, so
        // a stalled window stays bit-stable.
        if (!win_valid_q || i_win_ready) begin
          win_data_d  = win_mux;
          win_valid_d = 1'b1;
          if (rd_col_q == RD_COL_LAST) begin
            state_d = DRAIN;
          end else begin
            rd_col_d = rd_col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (rel_ev) begin
          win_valid_d = 1'b0;
          intr_d      = 1'b1;
          rd_base_d   = (rd_base_q == LINE_LAST) ? '0 : rd_base_q + LW'(1);
          rd_col_d    = '0;
          state_d     = (occ_d >= OCC_K) ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      state_q     <= IDLE;
      wr_col_q    <= '0;
      wr_line_q   <= '0;
      rd_col_q    <= '0;
      rd_base_q   <= '0;
      occ_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      wr_line_q   <= wr_line_d;
      rd_col_q    <= rd_col_d;
      rd_base_q   <= rd_base_d;
      occ_q       <= occ_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// tb/tb_line_window_ctrl.sv - self-checking bench for line_window_ctrl
module tb_line_window_ctrl;

  localparam int DW = 8;
  localparam int LL = 8;
  localparam int NL = 4;
  localparam int K  = 3;
  localparam int WW = K*K*DW;
  localparam int OW = $clog2(NL+1);

  logic          axi_clk;
  logic          axi_reset;
  logic          i_data_valid;
  logic [DW-1:0] i_data;
  logic          o_data_ready;
  logic          o_win_valid;
  logic [WW-1:0] o_win_data;
  logic          i_win_ready;
  logic          o_intr;
  logic [OW-1:0] o_occupancy;

  int n_vec      = 0;
  int miss       = 0;
  int intr_cnt   = 0;
  int win_cnt    = 0;
  int ready_mode = 1;
  logic [WW-1:0] sb [$];

  line_window_ctrl #(
    .DATA_W   (DW),
    .LINE_LEN (LL),
    .NUM_LINES(NL),
    .KSIZE    (K)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .o_data_ready(o_data_ready),
    .o_win_valid (o_win_valid),
    .o_win_data  (o_win_data),
    .i_win_ready (i_win_ready),
    .o_intr      (o_intr),
    .o_occupancy (o_occupancy)
  );

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  // Window whose oldest row is image row 'base' and leftmost column 'col'.
  function automatic logic [WW-1:0] make_win(input int base, input int col);
    logic [WW-1:0] w;
    logic [DW-1:0] pix;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        pix = DW'((base + r) * 16 + col + c);
        w   = w | (WW'(pix) << ((r*K + c) * DW));
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input int base);
    for (int col = 0; col <= LL - K; col++) sb.push_back(make_win(base, col));
  endtask

  task automatic send_pixel(input int row, input int col);
    int t;
    i_data       = DW'(row * 16 + col);
    i_data_valid = 1'b1;
    t = 0;
    @(negedge axi_clk);
    while (!o_data_ready && t < 200) begin
      t++;
      @(negedge axi_clk);
    end
    if (!o_data_ready) check("send_timeout", 0, 1);
    @(posedge axi_clk);
    #1;
    i_data_valid = 1'b0;
  endtask

  task automatic send_line(input int row);
    for (int c = 0; c < LL; c++) send_pixel(row, c);
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget && sb.size() != 0; t++) @(negedge axi_clk);
    check("drain", sb.size(), 0);
    repeat (4) @(negedge axi_clk);
  endtask

  task automatic do_reset();
    @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset = 1'b1;
  endtask

  // Sole driver of i_win_ready: 0 = stall, 1 = always ready, 2 = toggle.
  initial begin
    i_win_ready = 1'b1;
    forever begin
      @(posedge axi_clk);
      #1;
      case (ready_mode)
        0:       i_win_ready = 1'b0;
        1:       i_win_ready = 1'b1;
        default: i_win_ready = !i_win_ready;
      endcase
    end
  end

  // Scoreboard: each accepted window must be the next expected one.
  always @(negedge axi_clk) begin
    if (axi_reset && o_win_valid && i_win_ready) begin
      win_cnt++;
      n_vec++;
      assert (sb.size() != 0) else begin
        miss++;
        $error("FAIL win_extra observed=%0h expected=none", o_win_data);
      end
      if (sb.size() != 0) begin
        logic [WW-1:0] exp_w;
        exp_w = sb.pop_front();
        assert (o_win_data === exp_w) else begin
          miss++;
          $error("FAIL win_data observed=%0h expected=%0h", o_win_data, exp_w);
        end
      end
    end
    if (o_intr) intr_cnt++;
  end

  initial begin
    int i0;
    int w0;
    axi_reset    = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    #12;
    check("reset_state", {o_win_valid, o_intr, o_data_ready, o_occupancy, o_win_data},
          {1'b0, 1'b0, 1'b1, 3'd0, 72'd0});
    @(posedge axi_clk);
    #1;
    axi_reset = 1'b1;

    // Full-rate single line set with first-window latency.
    ready_mode = 1;
    push_set(0);
    i0 = intr_cnt;
    send_line(0);
    send_line(1);
    send_line(2);
    @(negedge axi_clk);
    check("lat_cyc1", o_win_valid, 0);
    @(negedge axi_clk);
    check("lat_cyc2", o_win_valid, 0);
    @(negedge axi_clk);
    check("lat_cyc3", o_win_valid, 1);
    check("occ_three", o_occupancy, 3);
    wait_drain(100);
    check("t1_intr", intr_cnt - i0, 1);
    check("t1_occ", o_occupancy, 2);

    // Stalled downstream: ring fills, window 0 holds.
    do_reset();
    ready_mode = 0;
    push_set(0);
    push_set(1);
    i0 = intr_cnt;
    for (int r = 0; r < 4; r++) send_line(r);
    check("full_ready", o_data_ready, 0);
    check("full_occ", o_occupancy, 4);
    for (int t = 0; t < 20; t++) begin
      @(negedge axi_clk);
      check("hold", {o_win_valid, o_win_data}, {1'b1, make_win(0, 0)});
    end
    ready_mode = 1;
    wait_drain(200);
    check("t2_intr", intr_cnt - i0, 2);
    check("t2_occ", o_occupancy, 2);
    check("t2_ready", o_data_ready, 1);

    // Toggling backpressure.
    do_reset();
    ready_mode = 2;
    push_set(0);
    i0 = intr_cnt;
    w0 = win_cnt;
    for (int r = 0; r < 3; r++) send_line(r);
    wait_drain(200);
    check("t3_wins", win_cnt - w0, 6);
    check("t3_intr", intr_cnt - i0, 1);

    // Line-complete coincides with release: pixel 0x37 lands on the final accept.
    do_reset();
    ready_mode = 1;
    push_set(0);
    push_set(1);
    i0 = intr_cnt;
    for (int r = 0; r < 4; r++) send_line(r);
    check("coinc_occ", o_occupancy, 3);
    check("coinc_intr", o_intr, 1);
    wait_drain(200);
    check("t4_intr", intr_cnt - i0, 2);
    check("t4_occ", o_occupancy, 2);

    // Asynchronous reset during RUN, then a clean restart.
    do_reset();
    ready_mode = 0;
    for (int r = 0; r < 3; r++) send_line(r);
    for (int c = 0; c < 3; c++) send_pixel(3, c);
    @(negedge axi_clk);
    check("pre_rst_valid", o_win_valid, 1);
    #2;
    axi_reset = 1'b0;
    #1;
    check("async_rst", {o_win_valid, o_intr, o_data_ready, o_occupancy, o_win_data},
          {1'b0, 1'b0, 1'b1, 3'd0, 72'd0});
    sb.delete();
    @(posedge axi_clk);
    #1;
    axi_reset  = 1'b1;
    ready_mode = 1;
    push_set(0);
    for (int r = 0; r < 3; r++) send_line(r);
    wait_drain(100);
    check("t5_occ", o_occupancy, 2);

    // Ten continuous lines: pointers wrap the ring twice.
    do_reset();
    ready_mode = 1;
    for (int b = 0; b < 8; b++) push_set(b);
    i0 = intr_cnt;
    for (int r = 0; r < 10; r++) send_line(r);
    wait_drain(400);
    check("t6_intr", intr_cnt - i0, 8);
    check("t6_occ", o_occupancy, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end

endmodule
